lockable_bank_arbiter: RTL and testbench
========================================

# lockable_bank_arbiter

Arbitrated controller for a bank of sticky-lock 8-bit configuration registers. Several requesters (e.g. a CPU bridge and a debug port) share one access path to the bank. The block round-robins between them, executes read / write / lock operations, and rejects any write to a locked register with an error response. Locks are one-way: a set lock bit clears only on reset.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- NUM_REGS, 4, number of registers, power of two (2..16)
- DW, 8, register data width
- AW, $clog2(NUM_REGS), address width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester request; held high until its ack
- req_op  in  2*NUM_REQ  per-requester opcode: 00 read, 01 write, 10 lock, 11 write-and-lock
- req_addr  in  AW*NUM_REQ  per-requester register index
- req_wdata  in  DW*NUM_REQ  per-requester write data
- lock_all  in  1  level input; sets every lock bit at the edge where it is sampled high
- gnt  out  NUM_REQ  one-hot; current owner of the bank
- ack  out  NUM_REQ  one-hot, one-cycle pulse; the operation for that requester is complete
- resp_err  out  1  valid with ack; operation rejected
- resp_rdata  out  DW  valid with ack; register value before the operation
- reg_q  out  DW*NUM_REGS  current contents of the register bank
- lock_q  out  NUM_REGS  current lock bits

## Operation
- State machine: IDLE, EXEC, RESP.
- IDLE, when any req is high: select the winner by round-robin, starting the search at pointer rr_ptr. Latch the winner's op, addr and wdata. Set gnt to the winner. Go to EXEC.
- EXEC, apply the operation to register addr:
  - Read: no state change; resp_err = 0.
  - Write:
    - If lock_q[addr] = 1 or lock_all = 1: no change; resp_err = 1.
    - Otherwise: reg_q[addr] <= wdata; resp_err = 0.
  - Lock: lock_q[addr] <= 1; resp_err = 0. Re-locking a locked register is not an error.
  - Write-and-lock: same write check as Write. If the write succeeds, data and lock update on the same edge. If it is rejected, the lock is still set and resp_err = 1.
  - In every case resp_rdata = reg_q[addr] as sampled at EXEC entry. Go to RESP.
- RESP:
  - ack[winner] pulses high.
  - gnt drops at the end of this cycle.
  - rr_ptr <= (winner + 1) mod NUM_REQ.
  - Go to IDLE.
- The latched payload is used throughout EXEC. Changes on the requester's inputs after the grant are ignored.
- A requester that drops req before its ack does not abort the operation; the ack is still issued.
- lock_all: when high at any edge, lock_q <= all ones, in every state. A write executing on that same edge is rejected (resp_err = 1).
- Locks never clear except on rst_n.

## Timing
- Reset values (asynchronous, on rst_n low):
  - state = IDLE, rr_ptr = 0
  - gnt = 0, ack = 0, resp_err = 0, resp_rdata = 0
  - reg_q = 0, lock_q = 0
- Latency. With req sampled high in IDLE at edge N:
  - gnt is high from edge N to N+3.
  - Register and lock update at edge N+2.
  - ack, resp_err and resp_rdata are valid for one cycle, between edges N+2 and N+3.
- Request-to-ack is 3 cycles.
- Throughput: one operation per 3 cycles. Back-to-back requests are granted at the edge after RESP.
- All outputs are registered. ack, resp_err and resp_rdata are held at 0 whenever ack is low.
- rst_n asserted mid-operation: the operation is abandoned, no ack is produced, and all state returns to reset values. A requester must re-issue after reset.
- Simultaneous requests: exactly one gnt bit is ever high. Under continuous contention, every requester is served within NUM_REQ operations.

## Test plan
- Reset, then requester 0 writes 0xA5 to reg 2 → ack[0] 3 cycles after req, resp_err = 0, resp_rdata = 0x00, reg_q[2] = 0xA5.
- Lock reg 2, then write 0x3C to it → lock ack resp_err = 0; write ack resp_err = 1; reg_q[2] stays 0xA5; reads return 0xA5.
- Write-and-lock 0x11 to unlocked reg 1 → reg_q[1] = 0x11 and lock_q[1] = 1 on the same edge. A repeat write-and-lock 0x22 → resp_err = 1, reg_q[1] = 0x11.
- Both requesters hold req continuously for 6 operations → grants alternate 0, 1, 0, 1, 0, 1; exactly one gnt bit high at a time; each ack matches the granted requester.
- lock_all pulsed on the EXEC edge of a write to reg 3 → resp_err = 1, reg_q[3] unchanged, lock_q = all ones.
- rst_n pulsed low during EXEC → no ack; reg_q and lock_q all 0. The next write to a previously locked register succeeds.

Source files
------------

// File: rtl/lockable_bank_arbiter.sv
// lockable_bank_arbiter: round-robin shared access to a bank of sticky-lock config registers
module lockable_bank_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int NUM_REGS = 4,
  parameter int DW       = 8,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [2*NUM_REQ-1:0]   req_op,
  input  logic [AW*NUM_REQ-1:0]  req_addr,
  input  logic [DW*NUM_REQ-1:0]  req_wdata,
  input  logic                   lock_all,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   resp_err,
  output logic [DW-1:0]          resp_rdata,
  output logic [DW*NUM_REGS-1:0] reg_q,
  output logic [NUM_REGS-1:0]    lock_q
);
  localparam int RW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_d;
  logic phase, grant, apply, wr_blk, wr_ok;
  logic [RW-1:0] rr_ptr, win, start, nxt_ptr, off, pick;
  logic [RW:0] sum;
  logic [NUM_REQ-1:0] dbl;
  logic [1:0] op;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [1:0] op_a [NUM_REQ];
  logic [AW-1:0] addr_a [NUM_REQ];
  logic [DW-1:0] wd_a [NUM_REQ];
  logic [DW-1:0] regs [NUM_REGS];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign op_a[g]   = req_op[2*g +: 2];
    assign addr_a[g] = req_addr[AW*g +: AW];
    assign wd_a[g]   = req_wdata[DW*g +: DW];
  end
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    assign reg_q[DW*g +: DW] = regs[g];
  end
  // Rotate requests so the search starts at the pointer; in RESP the pointer update is still pending.
  always_comb begin
    nxt_ptr = (win == RW'(NUM_REQ-1)) ? '0 : win + 1'b1;
    start = (state == RESP) ? nxt_ptr : rr_ptr;
    dbl = NUM_REQ'({req, req} >> start);
    off = '0;
    for (int j = NUM_REQ-1; j >= 0; j--) if (dbl[j]) off = RW'(j);
    sum = {1'b0, start} + {1'b0, off};
    pick = (sum >= (RW+1)'(NUM_REQ)) ? RW'(sum - (RW+1)'(NUM_REQ)) : sum[RW-1:0];
    grant = (state != EXEC) && |req;
    apply = (state == EXEC) && phase;
    wr_blk = lock_q[addr] | lock_all;
    wr_ok = op[0] & ~wr_blk;
    state_d = grant ? EXEC : (state == RESP) ? IDLE : apply ? RESP : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= 1'b0;
      rr_ptr <= '0;
      win <= '0;
      op <= '0;
      addr <= '0;
      wdata <= '0;
      gnt <= '0;
      ack <= '0;
      resp_err <= 1'b0;
      resp_rdata <= '0;
      lock_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state <= state_d;
      phase <= (state == EXEC) & ~phase;
      if (grant) begin
        win <= pick;
        op <= op_a[pick];
        addr <= addr_a[pick];
        wdata <= wd_a[pick];
      end
      gnt <= grant ? NUM_REQ'(1) << pick : (state == RESP) ? '0 : gnt;
      if (state == RESP) rr_ptr <= nxt_ptr;
      ack <= apply ? NUM_REQ'(1) << win : '0;
      resp_err <= apply & op[0] & wr_blk;
      resp_rdata <= apply ? regs[addr] : '0;
      if (apply & wr_ok) regs[addr] <= wdata;
      lock_q <= lock_all ? '1 : (apply & op[1]) ? lock_q | (NUM_REGS'(1) << addr) : lock_q;
    end
  end
endmodule

// File: tb/tb_lockable_bank_arbiter.sv
// tb_lockable_bank_arbiter: directed and random checks against a transaction-level model of the bank
module tb_lockable_bank_arbiter;
  localparam int NR = 2, NG = 4, DW = 8, AW = 2;
  logic clk = 0, rst_n = 0, lock_all = 0;
  logic [NR-1:0] req = '0;
  logic [2*NR-1:0] req_op;
  logic [AW*NR-1:0] req_addr;
  logic [DW*NR-1:0] req_wdata;
  logic [NR-1:0] gnt, ack;
  logic resp_err;
  logic [DW-1:0] resp_rdata;
  logic [DW*NG-1:0] reg_q;
  logic [NG-1:0] lock_q;
  logic [1:0] r_op [NR];
  logic [AW-1:0] r_addr [NR];
  logic [7:0] r_wd [NR];
  int n_chk = 0, n_fail = 0;

  logic [7:0] m_regs [NG];
  logic [NG-1:0] m_locks;
  int m_t, m_win, m_rr, m_addr;
  logic [1:0] m_op;
  logic [7:0] m_wd;
  logic [NR-1:0] exp_gnt, exp_ack;
  logic exp_err;
  logic [7:0] exp_rd;
  logic [31:0] exp_regq;

  lockable_bank_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .lock_all(lock_all), .gnt(gnt), .ack(ack), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .reg_q(reg_q), .lock_q(lock_q)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_op[2*i +: 2] = r_op[i];
      req_addr[AW*i +: AW] = r_addr[i];
      req_wdata[8*i +: 8] = r_wd[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NG; i++) m_regs[i] = '0;
    m_locks = '0; m_t = 0; m_win = 0; m_rr = 0; m_addr = 0; m_op = '0; m_wd = '0;
    exp_gnt = '0; exp_ack = '0; exp_err = 0; exp_rd = '0;
  endtask

  // One clock edge of the bank: m_t counts cycles since the grant (0 = nothing in flight).
  task automatic model_step();
    logic blocked;
    exp_ack = '0; exp_err = 0; exp_rd = '0;
    if (m_t == 2) begin
      exp_rd = m_regs[m_addr];
      blocked = m_locks[m_addr] || lock_all;
      if (m_op[0] && !blocked) m_regs[m_addr] = m_wd;
      if (m_op[1]) m_locks[m_addr] = 1'b1;
      exp_err = m_op[0] && blocked;
      exp_ack[m_win] = 1'b1;
      m_t = 3;
    end else if (m_t == 1) m_t = 2;
    else begin
      if (m_t == 3) begin
        m_rr = (m_win + 1) % NR;
        exp_gnt = '0;
        m_t = 0;
      end
      for (int k = 0; k < NR; k++) begin
        int w;
        w = (m_rr + k) % NR;
        if (m_t == 0 && req[w]) begin
          m_win = w; m_op = r_op[w]; m_addr = int'(r_addr[w]); m_wd = r_wd[w];
          exp_gnt = '0; exp_gnt[w] = 1'b1;
          m_t = 1;
        end
      end
    end
    if (lock_all) m_locks = '1;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NG; i++) exp_regq[8*i +: 8] = m_regs[i];
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("ack", 32'(ack), 32'(exp_ack));
    chk("resp_err", 32'(resp_err), 32'(exp_err));
    chk("resp_rdata", 32'(resp_rdata), 32'(exp_rd));
    chk("reg_q", reg_q, exp_regq);
    chk("lock_q", 32'(lock_q), 32'(m_locks));
    chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic do_op(input int r, input logic [1:0] op, input logic [1:0] a, input logic [7:0] d,
                       input bit la, output logic [7:0] rd, output logic err, output int lat);
    req[r] = 1'b1; r_op[r] = op; r_addr[r] = a; r_wd[r] = d;
    lat = 0; rd = '0; err = 0;
    for (int i = 1; i <= 10; i++) begin
      if (la && i == 3) lock_all = 1'b1;
      tick();
      lock_all = 1'b0;
      if (ack[r]) begin
        lat = i; rd = resp_rdata; err = resp_err;
        break;
      end
    end
    req[r] = 1'b0;
    if (lat == 0) begin
      n_chk++; n_fail++;
      $display("FAIL ack_timeout: requester %0d got no ack within 10 cycles", r);
    end
    tick();
  endtask

  initial begin
    logic [7:0] rd;
    logic err;
    int lat, n;
    bit pend [NR];
    for (int i = 0; i < NR; i++) begin r_op[i] = '0; r_addr[i] = '0; r_wd[i] = '0; pend[i] = 0; end
    model_reset();
    tick(); tick();
    chk("reset_reg_q", reg_q, 32'h0);
    chk("reset_lock_q", 32'(lock_q), 32'h0);
    rst_n = 1'b1;
    tick();

    do_op(0, 2'b01, 2'd2, 8'hA5, 0, rd, err, lat);
    chk("wr_latency", 32'(lat), 32'd3);
    chk("wr_err", 32'(err), 32'd0);
    chk("wr_rdata", 32'(rd), 32'h00);
    chk("wr_reg2", 32'(reg_q[23:16]), 32'hA5);
    chk("model_reg2", 32'(m_regs[2]), 32'hA5);

    do_op(0, 2'b10, 2'd2, 8'h00, 0, rd, err, lat);
    chk("lock_err", 32'(err), 32'd0);
    chk("lock_bit2", 32'(lock_q[2]), 32'd1);
    do_op(0, 2'b01, 2'd2, 8'h3C, 0, rd, err, lat);
    chk("locked_wr_err", 32'(err), 32'd1);
    chk("locked_reg2", 32'(reg_q[23:16]), 32'hA5);
    do_op(1, 2'b00, 2'd2, 8'h00, 0, rd, err, lat);
    chk("rd_locked", 32'(rd), 32'hA5);
    chk("rd_err", 32'(err), 32'd0);

    do_op(0, 2'b11, 2'd1, 8'h11, 0, rd, err, lat);
    chk("wl_err", 32'(err), 32'd0);
    chk("wl_reg1", 32'(reg_q[15:8]), 32'h11);
    chk("wl_lock1", 32'(lock_q[1]), 32'd1);
    do_op(0, 2'b11, 2'd1, 8'h22, 0, rd, err, lat);
    chk("wl2_err", 32'(err), 32'd1);
    chk("wl2_reg1", 32'(reg_q[15:8]), 32'h11);
    chk("model_lock", 32'(m_locks), 32'h6);

    do_op(1, 2'b00, 2'd0, 8'h00, 0, rd, err, lat);
    r_op[0] = 2'b00; r_op[1] = 2'b00;
    req = 2'b11;
    n = 0;
    for (int i = 0; i < 40 && n < 6; i++) begin
      tick();
      if (ack != 0) begin
        chk("rr_order", 32'(ack), (n % 2 == 0) ? 32'd1 : 32'd2);
        n++;
      end
    end
    req = '0;
    chk("rr_count", 32'(n), 32'd6);
    tick();

    do_op(0, 2'b01, 2'd3, 8'h77, 1, rd, err, lat);
    chk("lock_all_err", 32'(err), 32'd1);
    chk("lock_all_reg3", 32'(reg_q[31:24]), 32'h00);
    chk("lock_all_bits", 32'(lock_q), 32'hF);

    req[0] = 1'b1; r_op[0] = 2'b01; r_addr[0] = 2'd2; r_wd[0] = 8'h99;
    tick(); tick();
    chk("exec_gnt", 32'(gnt), 32'd1);
    rst_n = 1'b0; req = '0;
    model_reset();
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_reg_q", reg_q, 32'h0);
    chk("rst_lock_q", 32'(lock_q), 32'h0);
    tick(); chk("rst_ack2", 32'(ack), 32'd0);
    tick(); chk("rst_ack3", 32'(ack), 32'd0);
    rst_n = 1'b1;
    tick();
    do_op(0, 2'b01, 2'd2, 8'h5A, 0, rd, err, lat);
    chk("post_rst_err", 32'(err), 32'd0);
    chk("post_rst_reg2", 32'(reg_q[23:16]), 32'h5A);

    for (int c = 0; c < 1500; c++) begin
      tick();
      lock_all = ($urandom_range(59) == 0);
      if (c == 750) begin
        rst_n = 1'b0; req = '0; lock_all = 1'b0;
        model_reset();
        for (int r = 0; r < NR; r++) pend[r] = 0;
        tick(); tick();
        rst_n = 1'b1;
      end
      for (int r = 0; r < NR; r++) begin
        if (exp_ack[r]) begin
          req[r] = 1'b0; pend[r] = 0;
        end else if (exp_gnt[r] && m_t == 1) begin
          r_op[r] = 2'($urandom); r_addr[r] = 2'($urandom); r_wd[r] = 8'($urandom);
          if ($urandom_range(3) == 0) req[r] = 1'b0;
        end
        if (!pend[r] && $urandom_range(2) == 0) begin
          pend[r] = 1; req[r] = 1'b1;
          r_op[r] = 2'($urandom); r_addr[r] = 2'($urandom); r_wd[r] = 8'($urandom);
        end
      end
    end
    req = '0; lock_all = 1'b0;
    repeat (6) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
